// File: rtl/clock_divider.sv
// Synchronous clock divider: clk_out is a registered 50 %-duty square wave
// with a half-period of n clk cycles (f_out = f_clk / (2*n)).
module clock_divider #(
  parameter int unsigned n = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic clk_out
);

  localparam int unsigned W = (n > 1) ? $clog2(n) : 1;
  localparam logic [W-1:0] LP_TERM = W'(n - 1);

  if (n < 1) begin : g_bad_n
    $error("clock_divider: n must be at least 1");
  end

  logic [W-1:0] r_cnt;
  logic         r_clk_out;
  logic         w_terminal;

  // The counter never passes LP_TERM, so an equality compare is sufficient.
  assign w_terminal = (r_cnt == LP_TERM);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_clk_out <= 1'b0;
    end else if (w_terminal) begin
      r_cnt     <= '0;
      r_clk_out <= ~r_clk_out;
    end else begin
      r_cnt     <= r_cnt + W'(1);
    end
  end

  assign clk_out = r_clk_out;

endmodule

// File: tb/tb_clock_divider.sv
// Bench for clock_divider: a vector table on an n=2 instance plus hand-written
// sequences on n=1, n=5 and n=3 instances, all checked against a cycle model.
module tb_clock_divider;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst2 = 1'b1, rst1 = 1'b1, rst5 = 1'b1, rst3 = 1'b1;
  logic out2, out1, out5, out3;

  clock_divider #(2) u_dut2 (.clk(clk), .reset(rst2), .clk_out(out2));
  clock_divider #(1) u_dut1 (.clk(clk), .reset(rst1), .clk_out(out1));
  clock_divider #(5) u_dut5 (.clk(clk), .reset(rst5), .clk_out(out5));
  clock_divider #(3) u_dut3 (.clk(clk), .reset(rst3), .clk_out(out3));

  int n_checks = 0;
  int n_pass   = 0;

  // Expected {clk_out, cnt} pushed when the stimulus is driven.
  logic [32:0] exp_q[$];

  typedef struct {
    logic rst;
    logic exp_out;
    int   exp_cnt;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // clk_out after the k-th edge since release (k = 0 is E0): one toggle per n edges.
  function automatic logic model_out(input int k, input int nn);
    return logic'(((k + 1) / nn) % 2);
  endfunction

  initial begin
    logic [32:0] exp_v;
    longint      t_rise1, t_fall1, t_rise2;
    logic        prev;
    int          rises, bad_len, last_tog, first_rise_k, held_bad;

    vecs[0]  = '{1'b1, 1'b0, 0};
    vecs[1]  = '{1'b0, 1'b0, 1};
    vecs[2]  = '{1'b0, 1'b1, 0};
    vecs[3]  = '{1'b0, 1'b1, 1};
    vecs[4]  = '{1'b0, 1'b0, 0};
    vecs[5]  = '{1'b0, 1'b0, 1};
    vecs[6]  = '{1'b0, 1'b1, 0};
    vecs[7]  = '{1'b1, 1'b0, 0};  // reset while clk_out is high
    vecs[8]  = '{1'b0, 1'b0, 1};
    vecs[9]  = '{1'b0, 1'b1, 0};
    vecs[10] = '{1'b0, 1'b1, 1};
    vecs[11] = '{1'b0, 1'b0, 0};
    vecs[12] = '{1'b0, 1'b0, 1};
    vecs[13] = '{1'b1, 1'b0, 0};  // reset on terminal count with clk_out low
    vecs[14] = '{1'b0, 1'b0, 1};
    vecs[15] = '{1'b0, 1'b1, 0};

    // n = 2 table; release happens at t = 6, so E0 is the 15 ns edge.
    t_rise1 = -1; t_fall1 = -1; t_rise2 = -1;
    prev = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rst2 = vecs[i].rst;
      exp_q.push_back({vecs[i].exp_out, 32'(vecs[i].exp_cnt)});
      @(posedge clk);
      #1;
      exp_v = exp_q.pop_front();
      check($sformatf("n2_out[%0d]", i), longint'(out2), longint'(exp_v[32]));
      check($sformatf("n2_cnt[%0d]", i), longint'(u_dut2.r_cnt), longint'(exp_v[31:0]));
      if (i < 7) begin
        if (out2 && !prev && t_rise1 < 0) t_rise1 = $time - 1;
        else if (out2 && !prev) t_rise2 = $time - 1;
        if (!out2 && prev && t_fall1 < 0) t_fall1 = $time - 1;
      end
      prev = out2;
    end
    check("n2_rise1_time", t_rise1, 25);
    check("n2_fall1_time", t_fall1, 45);
    check("n2_rise2_time", t_rise2, 65);

    // n = 1: toggles on every edge after release, cnt stays 0.
    @(posedge clk); #1;
    check("n1_reset_out", longint'(out1), 0);
    rst1 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      check($sformatf("n1_out[%0d]", k), longint'(out1), longint'(model_out(k, 1)));
      check($sformatf("n1_cnt[%0d]", k), longint'(u_dut1.r_cnt), 0);
    end

    // n = 5: 100 cycles give 10 full periods, every phase 5 cycles long.
    rst5 = 1'b0;
    prev = out5; rises = 0; bad_len = 0; last_tog = -1; first_rise_k = -1;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      check($sformatf("n5_out[%0d]", k), longint'(out5), longint'(model_out(k, 5)));
      if (out5 != prev) begin
        if (out5) rises++;
        if (out5 && first_rise_k < 0) first_rise_k = k;
        if (last_tog >= 0 && (k - last_tog) != 5) bad_len++;
        last_tog = k;
      end
      prev = out5;
    end
    check("n5_periods", rises, 10);
    check("n5_phase_len_bad", bad_len, 0);
    check("n5_first_rise_edge", first_rise_k, 4);
    repeat (4) @(posedge clk);
    #1;
    check("n5_cnt_at_term", longint'(u_dut5.r_cnt), 4);
    rst5 = 1'b1;
    @(posedge clk); #1;
    check("n5_term_reset_out", longint'(out5), 0);
    check("n5_term_reset_cnt", longint'(u_dut5.r_cnt), 0);

    // n = 3: reset held for 20 cycles, then first rise n edges after release.
    held_bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (out3 !== 1'b0 || u_dut3.r_cnt !== '0) held_bad++;
    end
    check("n3_held_reset_bad", held_bad, 0);
    #($urandom_range(1, 3));
    rst3 = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      check($sformatf("n3_out[%0d]", k), longint'(out3), longint'(model_out(k, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
